// File: rtl/ysyx_24110006_axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM front-end: response codes, FSM state
// encodings, LFSR seed and the mapped-region address check.
package ysyx_24110006_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_ACCESS,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_ACCESS,
    W_RESP
  } wr_state_t;

  // 33-bit arithmetic so regions near the top of the address space cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [32:0] w_off;
    w_off = {1'b0, addr} - {1'b0, base};
    return ({1'b0, addr} >= {1'b0, base}) && (w_off < {1'b0, size});
  endfunction

endpackage

// File: rtl/ysyx_24110006_axil_sram_delay_cnt.sv
// 5-bit loadable down-counter used to time the wait state of each FSM.
// o_done flags the last wait cycle (count of 1).
module ysyx_24110006_delay_cnt (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  input  logic       i_en,
  output logic       o_done
);

  logic [4:0] r_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 5'd0)) begin
      r_cnt <= r_cnt - 5'd1;
    end
  end

  assign o_done = (r_cnt == 5'd1);

endmodule

// File: rtl/ysyx_24110006_axil_sram.sv
// AXI4-Lite slave front-end for the DPI SRAM model with independent read/write FSMs.
// Define SRAM_RAND_DELAY_EN to add LFSR-driven extra latency on both channels.
module ysyx_24110006_axil_sram
  import ysyx_24110006_axil_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1,
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE  = 32'h0800_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [31:0] i_araddr,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_awaddr,
  input  logic        i_wvalid,
  output logic        o_wready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_bvalid,
  input  logic        i_bready,
  output logic [1:0]  o_bresp,
  output logic        o_sram_ren,
  output logic [31:0] o_sram_raddr,
  input  logic [31:0] i_sram_rdata,
  output logic        o_sram_wen,
  output logic [31:0] o_sram_waddr,
  output logic [31:0] o_sram_wdata,
  output logic [7:0]  o_sram_wmask
);

  localparam logic [4:0] RD_LAT5 = 5'(RD_LATENCY);
  localparam logic [4:0] WR_LAT5 = 5'(WR_LATENCY);

  rd_state_t   r_rd_state, w_rd_next;
  wr_state_t   r_wr_state, w_wr_next;

  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;
  logic        w_rd_inrange;
  logic        w_rd_load;
  logic        w_rd_done;
  logic [4:0]  w_rd_load_val;

  logic        r_aw_held;
  logic        r_w_held;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_wr_both;
  logic        w_wr_inrange;
  logic        w_wr_load;
  logic        w_wr_done;
  logic [4:0]  w_wr_load_val;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_rd_load_val = RD_LAT5 + {2'b00, r_lfsr[2:0]};
  assign w_wr_load_val = WR_LAT5 + {2'b00, r_lfsr[5:3]};
`else
  assign w_rd_load_val = RD_LAT5;
  assign w_wr_load_val = WR_LAT5;
`endif

  // ---------------- read channel ----------------
  assign w_ar_hs      = i_arvalid && (r_rd_state == R_IDLE);
  assign w_rd_inrange = addr_in_range(r_araddr, ADDR_BASE, ADDR_SIZE);

  ysyx_24110006_delay_cnt u_rd_cnt (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_rd_load),
    .i_load_val (w_rd_load_val),
    .i_en       (r_rd_state == R_WAIT),
    .o_done     (w_rd_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    w_rd_load = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (i_arvalid) begin
          w_rd_load = 1'b1;
          w_rd_next = (w_rd_load_val == 5'd0) ? R_ACCESS : R_WAIT;
        end
      end
      R_WAIT:   if (w_rd_done) w_rd_next = R_ACCESS;
      R_ACCESS: w_rd_next = R_RESP;
      R_RESP:   if (i_rready) w_rd_next = R_IDLE;
      default:  w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_araddr <= i_araddr;
      end
      if (r_rd_state == R_ACCESS) begin
        r_rdata <= w_rd_inrange ? i_sram_rdata : '0;
        r_rresp <= w_rd_inrange ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  assign o_arready    = (r_rd_state == R_IDLE);
  assign o_rvalid     = (r_rd_state == R_RESP);
  assign o_rdata      = r_rdata;
  assign o_rresp      = r_rresp;
  assign o_sram_ren   = (r_rd_state == R_ACCESS) && w_rd_inrange;
  assign o_sram_raddr = r_araddr;

  // ---------------- write channel ----------------
  // AW and W are latched independently; the FSM leaves idle once both are held.
  assign o_awready    = (r_wr_state == W_IDLE) && !r_aw_held;
  assign o_wready     = (r_wr_state == W_IDLE) && !r_w_held;
  assign w_aw_hs      = i_awvalid && o_awready;
  assign w_w_hs       = i_wvalid && o_wready;
  assign w_wr_both    = (r_wr_state == W_IDLE) && r_aw_held && r_w_held;
  assign w_wr_inrange = addr_in_range(r_awaddr, ADDR_BASE, ADDR_SIZE);

  ysyx_24110006_delay_cnt u_wr_cnt (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_wr_load),
    .i_load_val (w_wr_load_val),
    .i_en       (r_wr_state == W_WAIT),
    .o_done     (w_wr_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_state <= W_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
    end
  end

  always_comb begin
    w_wr_next = r_wr_state;
    w_wr_load = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (r_aw_held && r_w_held) begin
          w_wr_load = 1'b1;
          w_wr_next = (w_wr_load_val == 5'd0) ? W_ACCESS : W_WAIT;
        end
      end
      W_WAIT:   if (w_wr_done) w_wr_next = W_ACCESS;
      W_ACCESS: w_wr_next = W_RESP;
      W_RESP:   if (i_bready) w_wr_next = W_IDLE;
      default:  w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= i_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end
      if (w_wr_both) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (r_wr_state == W_ACCESS) begin
        r_bresp <= w_wr_inrange ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  assign o_bvalid     = (r_wr_state == W_RESP);
  assign o_bresp      = r_bresp;
  assign o_sram_wen   = (r_wr_state == W_ACCESS) && w_wr_inrange;
  assign o_sram_waddr = r_awaddr;
  assign o_sram_wdata = r_wdata;
  assign o_sram_wmask = {4'b0000, r_wstrb};

endmodule

// File: tb/tb_ysyx_24110006_axil_sram.sv
// Directed self-checking bench for ysyx_24110006_axil_sram with a byte-masked SRAM model.
module tb_ysyx_24110006_axil_sram;

  localparam int RD_LAT = 1;
  localparam int WR_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        ren, wen;
  logic [31:0] raddr, sram_rdata, waddr, sdata;
  logic [7:0]  wmask;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ren_cnt = 0, ren_cyc = 0, wen_cnt = 0, wen_cyc = 0;
  logic [31:0] ren_addr = '0, wen_addr = '0, wen_data = '0;
  logic [7:0]  wen_mask = '0;

  logic [31:0] mem [0:255];
  logic        mem_inited = 1'b0;

  always #5 clk = ~clk;

  ysyx_24110006_axil_sram #(
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_arvalid    (arvalid),
    .o_arready    (arready),
    .i_araddr     (araddr),
    .o_rvalid     (rvalid),
    .i_rready     (rready),
    .o_rdata      (rdata),
    .o_rresp      (rresp),
    .i_awvalid    (awvalid),
    .o_awready    (awready),
    .i_awaddr     (awaddr),
    .i_wvalid     (wvalid),
    .o_wready     (wready),
    .i_wdata      (wdata),
    .i_wstrb      (wstrb),
    .o_bvalid     (bvalid),
    .i_bready     (bready),
    .o_bresp      (bresp),
    .o_sram_ren   (ren),
    .o_sram_raddr (raddr),
    .i_sram_rdata (sram_rdata),
    .o_sram_wen   (wen),
    .o_sram_waddr (waddr),
    .o_sram_wdata (sdata),
    .o_sram_wmask (wmask)
  );

  assign sram_rdata = mem[raddr[9:2]];

  // Word i initialised to 32'h1000_0000 + i.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem_inited <= 1'b1;
    end else if (wen) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[waddr[9:2]][8*b +: 8] <= sdata[8*b +: 8];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ren) begin
      ren_cnt++; ren_cyc = cyc; ren_addr = raddr;
    end
    if (wen) begin
      wen_cnt++; wen_cyc = cyc; wen_addr = waddr; wen_data = sdata; wen_mask = wmask;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] ed,
                         input logic [1:0] er, input int ns);
    int c0, rc0, n;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a; rready = 1'b1;
    c0 = cyc; rc0 = ren_cnt;
    #1 check({tag, "_arready"}, 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 64'(cyc - c0), 64'(2 + RD_LAT));
    check({tag, "_rdata"}, 64'(rdata), 64'(ed));
    check({tag, "_rresp"}, 64'(rresp), 64'(er));
    check({tag, "_nren"}, 64'(ren_cnt - rc0), 64'(ns));
    if (ns != 0) begin
      check({tag, "_raddr"}, 64'(ren_addr), 64'(a));
      check({tag, "_rencyc"}, 64'(ren_cyc - c0), 64'(1 + RD_LAT));
    end
    @(posedge clk); #1;
    rready = 1'b0;
    #1 check({tag, "_rdone"}, 64'({rvalid, arready}), 64'b01);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_off,
                          input logic [1:0] er, input int ns);
    int c0, wc0, n;
    @(posedge clk); #1;
    c0 = cyc; wc0 = wen_cnt;
    awaddr = a; bready = 1'b1;
    for (int k = 0; k <= w_off; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      awvalid = (k == 0);
      if (k == w_off) begin
        wvalid = 1'b1; wdata = d; wstrb = s;
      end
      #1;
      if (k == 1) check({tag, "_ready_split"}, 64'({awready, wready}), 64'b01);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 64'(cyc - c0), 64'(w_off + 3 + WR_LAT));
    check({tag, "_bresp"}, 64'(bresp), 64'(er));
    check({tag, "_nwen"}, 64'(wen_cnt - wc0), 64'(ns));
    if (ns != 0) begin
      check({tag, "_wport"}, {wen_addr, wen_data}, {a, d});
      check({tag, "_wmask"}, 64'(wen_mask), 64'({4'b0000, s}));
      check({tag, "_wencyc"}, 64'(wen_cyc - c0), 64'(w_off + 2 + WR_LAT));
    end
    @(posedge clk); #1;
    bready = 1'b0;
    #1 check({tag, "_bdone"}, 64'({bvalid, awready, wready}), 64'b011);
  endtask

  initial begin
    int rc0;
    logic seen;
    #3;
    check("rst_ready", 64'({arready, awready, wready}), 64'b111);
    check("rst_valid", 64'({rvalid, bvalid, ren, wen}), 64'd0);
    check("rst_resp", 64'({rdata, rresp, bresp}), 64'd0);
    check("rst_sram_addr", {raddr, waddr}, 64'd0);
    check("rst_sram_data", 64'({sdata, wmask}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_read("rd1", 32'h8000_0010, 32'h1000_0004, 2'b00, 1);
    do_write("wr1", 32'h8000_0020, 32'hDEAD_BEEF, 4'b0101, 3, 2'b00, 1);
    do_read("rdback", 32'h8000_0020, 32'h10AD_00EF, 2'b00, 1);
    do_write("wr0strb", 32'h8000_0030, 32'hFFFF_FFFF, 4'b0000, 0, 2'b00, 1);
    do_read("rd0strb", 32'h8000_0030, 32'h1000_000C, 2'b00, 1);

    // R-channel backpressure
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h8000_0010; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int n = 0; n < 50 && !rvalid; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", 64'({rvalid, arready, rdata}), {31'd0, 1'b1, 1'b0, 32'h1000_0004});
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    #1 check("bp_release", 64'({rvalid, arready}), 64'b01);

    do_read("rd_oor", 32'h7FFF_FFFC, 32'h0, 2'b11, 0);
    do_write("wr_oor", 32'h8800_0000, 32'h1234_5678, 4'hF, 0, 2'b11, 0);
    do_read("rd_top", 32'h87FF_FFFC, 32'h1000_00FF, 2'b00, 1);

    // Reset asserted while the read sits in its wait state
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h8000_0050; rready = 1'b1; rc0 = ren_cnt;
    @(posedge clk); #1;
    arvalid = 1'b0;
    #1 rst = 1'b1;
    #1 check("rstmid_now", 64'({arready, rvalid}), 64'b10);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rvalid) seen = 1'b1;
    end
    check("rstmid_quiet", 64'({seen, 31'(ren_cnt - rc0)}), 64'd0);
    rready = 1'b0;
    do_read("rd_after_rst", 32'h8000_0050, 32'h1000_0014, 2'b00, 1);

    fork
      do_read("cc_rd", 32'h8000_0040, 32'h1000_0010, 2'b00, 1);
      do_write("cc_wr", 32'h8000_0044, 32'hCAFE_F00D, 4'hF, 0, 2'b00, 1);
    join
    do_read("cc_back", 32'h8000_0044, 32'hCAFE_F00D, 2'b00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
